// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the core/memory handshake, plus the responder's
// state encoding.
package dbus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR_WAIT,
    ST_DATA_WAIT,
    ST_RESPOND
  } dbus_resp_state_t;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/responder_ram.sv
// Single-port word array with per-byte write enables and a registered read
// port. The read register is the responder's load data holding register.
module responder_ram #(
  parameter  int unsigned WORDS = 1024,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset so it can map onto a RAM macro; only the
  // read register is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_responder.sv
// Memory-side target of the dbus handshake: one request at a time, with
// configurable address/data latency and address-phase back-pressure.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned ADDR_LATENCY = 0,
  parameter int unsigned DATA_LATENCY = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  input  logic       hold
);

  localparam int unsigned    AW   = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0] ALAT = LAT_W'(ADDR_LATENCY);
  localparam logic [LAT_W-1:0] DLAT = LAT_W'(DATA_LATENCY);

  dbus_resp_state_t state_q, state_d;
  logic [LAT_W-1:0] acnt_q, acnt_d;
  logic [LAT_W-1:0] dcnt_q, dcnt_d;
  logic             store_q, store_d;

  logic             addr_phase;
  logic             addr_ok;
  logic             is_store;
  logic [AW-1:0]    word_idx;
  logic [3:0]       ram_be;
  logic             ram_re;
  logic [31:0]      ram_rdata;
  logic             unused_req_bits;

  assign addr_phase = (state_q == ST_IDLE) || (state_q == ST_ADDR_WAIT);
  assign addr_ok    = resetn && addr_phase && dreq.valid && !hold && (acnt_q == ALAT);
  assign is_store   = |dreq.strobe;
  assign word_idx   = dreq.addr[AW+1:2];
  assign ram_be     = addr_ok ? dreq.strobe : 4'b0000;
  assign ram_re     = addr_ok && !is_store;

  // Sub-word offset, upper address bits and size play no part in the access.
  assign unused_req_bits = ^{dreq.addr[31:AW+2], dreq.addr[1:0], dreq.size};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      store_q <= store_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    store_d = store_q;
    unique case (state_q)
      ST_IDLE, ST_ADDR_WAIT: begin
        if (addr_ok) begin
          // A one-cycle data latency skips the wait state entirely.
          state_d = (DLAT == LAT_W'(1)) ? ST_RESPOND : ST_DATA_WAIT;
          acnt_d  = '0;
          dcnt_d  = LAT_W'(1);
          store_d = is_store;
        end else if (dreq.valid) begin
          state_d = ST_ADDR_WAIT;
          if (acnt_q < ALAT) acnt_d = acnt_q + LAT_W'(1);
        end else begin
          state_d = ST_IDLE;
          acnt_d  = '0;
        end
      end
      ST_DATA_WAIT: begin
        dcnt_d = dcnt_q + LAT_W'(1);
        if (dcnt_q + LAT_W'(1) == DLAT) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = addr_ok;
    dresp.data_ok = (state_q == ST_RESPOND);
    if (dresp.data_ok && !store_q) dresp.data = ram_rdata;
  end

  responder_ram #(
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (resetn),
    .addr_i  (word_idx),
    .be_i    (ram_be),
    .wdata_i (dreq.data),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  a_addr_ok_phase: assert property (@(posedge clk) disable iff (!resetn)
    dresp.addr_ok |-> addr_phase);

  a_data_ok_pulse: assert property (@(posedge clk) disable iff (!resetn)
    dresp.data_ok |=> !dresp.data_ok);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: two instances with different latencies,
// checked every cycle against a transaction-level model of the responder.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int AL0 = 0, DL0 = 1;
  localparam int AL1 = 3, DL1 = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  dbus_req_t  dreq [2];
  dbus_resp_t dresp [2];
  logic       hold [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dbus_responder #(
    .MEM_WORDS (MEM_WORDS), .ADDR_LATENCY (AL0), .DATA_LATENCY (DL0)
  ) u_dut0 (
    .clk (clk), .resetn (resetn), .dreq (dreq[0]), .dresp (dresp[0]), .hold (hold[0])
  );

  dbus_responder #(
    .MEM_WORDS (MEM_WORDS), .ADDR_LATENCY (AL1), .DATA_LATENCY (DL1)
  ) u_dut1 (
    .clk (clk), .resetn (resetn), .dreq (dreq[1]), .dresp (dresp[1]), .hold (hold[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int al_of(input int i);
    return (i == 0) ? AL0 : AL1;
  endfunction

  function automatic int dl_of(input int i);
    return (i == 0) ? DL0 : DL1;
  endfunction

  // Transaction model: a request is taken once valid has been seen for
  // ADDR_LATENCY earlier consecutive cycles and hold is low; the answer
  // arrives DATA_LATENCY cycles later. Memory is a sparse word map.
  bit [31:0]   mem_m [int];
  int          run_m [2];
  bit          busy_m [2];
  int          remain_m [2];
  logic [31:0] rdata_m [2];
  bit          known_m [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        e_aok, e_dok;
      logic [31:0] e_data;
      int          key;
      if (!resetn) begin
        check($sformatf("dut%0d_rst_addr_ok", i), 32'(dresp[i].addr_ok), 0);
        check($sformatf("dut%0d_rst_data_ok", i), 32'(dresp[i].data_ok), 0);
        check($sformatf("dut%0d_rst_data", i), dresp[i].data, 0);
        run_m[i]  = 0;
        busy_m[i] = 1'b0;
      end else begin
        e_aok  = 1'b0;
        e_dok  = 1'b0;
        e_data = '0;
        if (busy_m[i]) begin
          e_dok  = (remain_m[i] == 0);
          e_data = e_dok ? rdata_m[i] : 32'h0;
        end else begin
          e_aok = dreq[i].valid && !hold[i] && (run_m[i] >= al_of(i));
        end
        check($sformatf("dut%0d_addr_ok", i), 32'(dresp[i].addr_ok), 32'(e_aok));
        check($sformatf("dut%0d_data_ok", i), 32'(dresp[i].data_ok), 32'(e_dok));
        if (!(e_dok && !known_m[i]))
          check($sformatf("dut%0d_data", i), dresp[i].data, e_data);

        if (busy_m[i]) begin
          if (remain_m[i] == 0) begin
            busy_m[i] = 1'b0;
            run_m[i]  = 0;
          end else begin
            remain_m[i]--;
          end
        end else if (e_aok) begin
          key = i * 65536 + int'((dreq[i].addr >> 2) % MEM_WORDS);
          if (dreq[i].strobe != 4'h0) begin
            bit [31:0] w;
            w = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (dreq[i].strobe[b]) w[8*b +: 8] = dreq[i].data[8*b +: 8];
            mem_m[key] = w;
            rdata_m[i] = 32'h0;
            known_m[i] = 1'b1;
          end else begin
            known_m[i] = mem_m.exists(key);
            rdata_m[i] = known_m[i] ? mem_m[key] : 32'h0;
          end
          busy_m[i]   = 1'b1;
          remain_m[i] = dl_of(i) - 1;
          run_m[i]    = 0;
        end else if (dreq[i].valid) begin
          run_m[i]++;
        end else begin
          run_m[i] = 0;
        end
      end
    end
  end

  // Present a request and hold it until addr_ok; a_lat is the 1-based cycle
  // of valid in which addr_ok was seen. hold is high for the first hold_cyc.
  task automatic issue(input int i, input logic [31:0] a, input logic [3:0] strb,
                       input logic [31:0] wdata, input int hold_cyc, output int a_lat);
    @(posedge clk); #1;
    dreq[i] = '{valid: 1'b1, addr: a, size: 3'd2, strobe: strb, data: wdata};
    hold[i] = (hold_cyc > 0);
    a_lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (dresp[i].addr_ok) begin
        a_lat = k;
        break;
      end
      @(posedge clk); #1;
      hold[i] = (k < hold_cyc);
    end
    @(posedge clk); #1;
    dreq[i].valid = 1'b0;
    hold[i] = 1'b0;
    check($sformatf("dut%0d_addr_ok_seen", i), 32'(a_lat != 0), 1);
  endtask

  task automatic wait_resp(input int i, output logic [31:0] data, output int d_lat);
    d_lat = 0;
    data  = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (dresp[i].data_ok) begin
        d_lat = k;
        data  = dresp[i].data;
        break;
      end
    end
    check($sformatf("dut%0d_data_ok_seen", i), 32'(d_lat != 0), 1);
  endtask

  task automatic txn(input int i, input logic [31:0] a, input logic [3:0] strb,
                     input logic [31:0] wdata, input int hold_cyc,
                     input int exp_alat, input int exp_dlat, input logic [31:0] exp_data,
                     input string tag);
    int          a_lat, d_lat;
    logic [31:0] rd;
    issue(i, a, strb, wdata, hold_cyc, a_lat);
    wait_resp(i, rd, d_lat);
    check({tag, "_addr_lat"}, 32'(a_lat), 32'(exp_alat));
    check({tag, "_data_lat"}, 32'(d_lat), 32'(exp_dlat));
    check({tag, "_data"}, rd, exp_data);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("pulse_addr_ok", 32'(dresp[1].addr_ok), 0);
    check("pulse_data_ok", 32'(dresp[1].data_ok), 0);
    check("pulse_data", dresp[1].data, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_lat, n_dok;
    for (int i = 0; i < 2; i++) begin
      dreq[i]     = '0;
      hold[i]     = 1'b0;
      run_m[i]    = 0;
      busy_m[i]   = 1'b0;
      remain_m[i] = 0;
      rdata_m[i]  = '0;
      known_m[i]  = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dut0_resp", 32'(dresp[0]), 0);
    check("reset_dut1_resp", 32'(dresp[1]), 0);
    #1 resetn = 1'b1;

    // Zero address latency, one-cycle data latency.
    txn(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 1, 1, 32'h0,        "d0_store");
    txn(0, 32'h10, 4'h0, 32'h0,        0, 1, 1, 32'hDEADBEEF, "d0_load");
    txn(0, 32'h12, 4'h4, 32'h00AB0000, 0, 1, 1, 32'h0,        "d0_bstore");
    txn(0, 32'h10, 4'h0, 32'h0,        0, 1, 1, 32'hDEABBEEF, "d0_bload");
    // Back-pressure for five cycles: taken in the sixth.
    txn(0, 32'h10, 4'h0, 32'h0,        5, 6, 1, 32'hDEABBEEF, "d0_hold");
    // Word index wraps at MEM_WORDS.
    txn(0, 32'h1000, 4'hF, 32'h12345678, 0, 1, 1, 32'h0,        "d0_alias_st");
    txn(0, 32'h0,    4'h0, 32'h0,        0, 1, 1, 32'h12345678, "d0_alias_ld");

    // Three cycles of address latency, four of data latency.
    txn(1, 32'h20, 4'hF, 32'hCAFEF00D, 0, 4, 4, 32'h0,        "d1_store");
    txn(1, 32'h20, 4'h0, 32'h0,        0, 4, 4, 32'hCAFEF00D, "d1_load");
    @(negedge clk);
    check("d1_data_ok_one_cycle", 32'(dresp[1].data_ok), 0);
    // hold does not stop the address counter.
    txn(1, 32'h20, 4'h0, 32'h0,        2, 4, 4, 32'hCAFEF00D, "d1_hold2");
    txn(1, 32'h20, 4'h0, 32'h0,        5, 6, 4, 32'hCAFEF00D, "d1_hold5");

    // Abandoned request: valid drops before acceptance, nothing written.
    @(posedge clk); #1;
    dreq[1] = '{valid: 1'b1, addr: 32'h20, size: 3'd2, strobe: 4'hF, data: 32'h11111111};
    repeat (2) begin
      @(posedge clk); #1;
    end
    dreq[1].valid = 1'b0;
    repeat (3) @(posedge clk);
    txn(1, 32'h20, 4'h0, 32'h0, 0, 4, 4, 32'hCAFEF00D, "d1_after_abandon");

    // Reset while a load waits for its data: the response is dropped.
    issue(1, 32'h20, 4'h0, 32'h0, 0, a_lat);
    reset_pulse();
    n_dok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dresp[1].data_ok) n_dok++;
    end
    check("rst_load_dropped", 32'(n_dok), 0);

    // Reset while a store waits: the write is already committed.
    issue(1, 32'h24, 4'hF, 32'hA5A55A5A, 0, a_lat);
    reset_pulse();
    repeat (2) @(posedge clk);
    txn(1, 32'h24, 4'h0, 32'h0, 0, 4, 4, 32'hA5A55A5A, "d1_after_rst_store");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Memory-side responder for the data bus: the target end of the `dbus_req_t`/`dbus_resp_t` handshake that the multi-cycle core drives as initiator. It accepts one request at a time, applies configurable address-phase and data-phase latency plus an external back-pressure input, and serves loads and byte-strobed stores from an internal word array. It stands in for the memory system in core-level simulation and lets the bench exercise every wait-state combination the core's load/store states must tolerate.

## Interface
- `MEM_WORDS`, default 1024: number of 32-bit words in the array (power of two).
- `ADDR_LATENCY`, default 0: cycles `dreq.valid` must be observed before `addr_ok` may assert (0..15).
- `DATA_LATENCY`, default 1: cycles from the `addr_ok` cycle to the `data_ok` cycle (1..15).
- `clk` in 1: clock, all state updates on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `dreq` in `dbus_req_t`: fields `valid`, `addr`[31:0], `size`, `strobe`[3:0], `data`[31:0].
- `dresp` out `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data`[31:0].
- `hold` in 1: address-phase back-pressure; while 1, `addr_ok` is forced 0.

## Operation
- States: IDLE, ADDR_WAIT, DATA_WAIT, RESPOND.
- Acceptance = `dreq.valid && dresp.addr_ok` in the same cycle; the initiator holds `dreq` stable until then.
- `addr_ok` (combinational) = state∈{IDLE, ADDR_WAIT} && `dreq.valid` && !`hold` && `acnt` == `ADDR_LATENCY`. Never asserted in DATA_WAIT or RESPOND.
- `acnt`: 4-bit, increments each cycle `valid` is high in IDLE/ADDR_WAIT while below `ADDR_LATENCY` (saturates; `hold` does not stop it); cleared on acceptance or when `valid` drops.
- IDLE: `valid` && no acceptance -> ADDR_WAIT; acceptance -> DATA_WAIT. ADDR_WAIT: `valid` low -> IDLE (attempt abandoned, no side effect); acceptance -> DATA_WAIT.
- On the acceptance edge: latch word index; if `strobe`≠0 write byte lanes where `strobe[i]`=1 (byte i = `data[8i+7:8i]`); if `strobe`==0 latch the array word (pre-write contents) into the read register. Stores return `data`=0.
- Word index = `addr[$clog2(MEM_WORDS)+1:2]`; `addr[1:0]` and upper bits ignored (aliasing wraps). `size` is ignored; `strobe` alone selects lanes.
- DATA_WAIT: `dcnt` counts from 1; when `dcnt` == `DATA_LATENCY` state is RESPOND. RESPOND: `data_ok`=1 for exactly one cycle, `dresp.data` = read register; next state IDLE.
- `dresp.data` = 0 whenever `data_ok`=0.

## Timing
- Reset values: state IDLE, `acnt`=`dcnt`=0, read register 0, `addr_ok`=0, `data_ok`=0, `data`=0. `addr_ok` gated by `resetn`. Array contents are not reset.
- `ADDR_LATENCY`=0, `hold`=0: `addr_ok` in the same cycle `valid` first rises.
- `data_ok` exactly `DATA_LATENCY` cycles after the acceptance cycle (`DATA_LATENCY`=1: next cycle).
- Back-to-back: earliest next acceptance is the cycle after `data_ok`; minimum period `DATA_LATENCY`+1 cycles.
- `hold` rising on the cycle `acnt` reaches `ADDR_LATENCY`: no acceptance; acceptance in the first cycle `hold`=0 with `valid`=1.
- Reset mid-transaction: in-flight response dropped (no `data_ok`). A store already accepted remains committed.

## Structure
- `dbus_req_t`/`dbus_resp_t` come from the shared common package. Add `dbus_resp_state_t` (4-state enum) to the same package.
- One sub-module: `responder_ram`, single-port `MEM_WORDS`×32 array with a 4-bit byte write-enable and synchronous read. The FSM, counters and output muxing stay in `dbus_responder`.

## Test plan
- Defaults: store addr 0x10, data 0xDEADBEEF, strobe 0xF; load 0x10 -> `addr_ok` same cycle as `valid`, `data_ok` next cycle with 0xDEADBEEF; store's `data_ok` carries 0.
- Byte strobe: after above, store 0x12 data 0x00AB0000 strobe 0x4; load 0x10 -> 0xDEABBEEF.
- `ADDR_LATENCY`=3, `DATA_LATENCY`=4: load -> `addr_ok` in 4th cycle of `valid`, `data_ok` 4 cycles later, one cycle wide.
- `hold` high 5 cycles from `valid` rise -> no `addr_ok` until `hold` falls, then acceptance that cycle; `valid` dropped in ADDR_WAIT -> back to IDLE, no write.
- Aliasing: `MEM_WORDS`=1024, store 0x1000 data 0x12345678; load 0x0 -> 0x12345678.
- `resetn` low during DATA_WAIT of a load -> outputs 0 immediately, no `data_ok`; during store DATA_WAIT -> later load returns stored value.
